// File: rtl/nfc_atom_ca_latch.sv
// Command/address latch engine: serialises up to five CLE/ALE bytes onto the NAND pins.
// Optional CE-held postamble before completion is enabled by NFC_CA_LATCH_POSTAMBLE_EN.
module nfc_atom_ca_latch #(
  parameter int unsigned NumberOfWays    = 4,
  parameter int unsigned CommandBit      = 6,
  parameter int unsigned WPCycles        = 2,
  parameter int unsigned WHCycles        = 2,
  parameter int unsigned PostambleCycles = 3
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [7:0]              iACG_Command,
  input  logic [NumberOfWays-1:0] iACG_TargetWay,
  input  logic [15:0]             iACG_NumOfData,
  input  logic                    iACG_CASelect,
  input  logic [39:0]             iACG_CAData,
  output logic                    oACG_Ready,
  output logic                    oACG_LastStep,
  output logic [NumberOfWays-1:0] oPO_CE_n,
  output logic                    oPO_CLE,
  output logic                    oPO_ALE,
  output logic                    oPO_WE_n,
  output logic [7:0]              oPO_DQ,
  output logic                    oPO_DQOE
);

`ifdef NFC_CA_LATCH_POSTAMBLE_EN
  typedef enum logic [2:0] {StIdle, StSetup, StWeLow, StWeHigh, StPost, StDone} state_e;
  localparam logic [3:0] PostLoad = 4'(PostambleCycles - 1);
`else
  typedef enum logic [2:0] {StIdle, StSetup, StWeLow, StWeHigh, StDone} state_e;
`endif

  localparam logic [3:0] WpLoad = 4'(WPCycles - 1);
  localparam logic [3:0] WhLoad = 4'(WHCycles - 1);

  state_e                  stateQ, stateD;
  logic [3:0]              timerQ, timerD;
  logic [2:0]              byteCntQ, byteCntD;
  logic [NumberOfWays-1:0] wayQ, wayD;
  logic                    caSelQ, caSelD;
  logic [39:0]             dataQ, dataD;
  logic [2:0]              effCount;

  logic                    readyD, lastStepD, cleD, aleD, weND, dqoeD;
  logic [NumberOfWays-1:0] ceND;
  logic [7:0]              dqD;

  logic unusedCommand;
  assign unusedCommand = ^iACG_Command;

  always_comb begin
    effCount = iACG_NumOfData[2:0];
    if (iACG_NumOfData == 16'd0) begin
      effCount = 3'd1;
    end else if (iACG_NumOfData > 16'd5) begin
      effCount = 3'd5;
    end
  end

  always_comb begin
    stateD   = stateQ;
    timerD   = timerQ;
    byteCntD = byteCntQ;
    wayD     = wayQ;
    caSelD   = caSelQ;
    dataD    = dataQ;
    case (stateQ)
      StIdle: begin
        if (iACG_Command[CommandBit]) begin
          stateD   = StSetup;
          timerD   = 4'd0;
          byteCntD = effCount;
          wayD     = iACG_TargetWay;
          caSelD   = iACG_CASelect;
          dataD    = iACG_CAData;
        end
      end
      StSetup: begin
        stateD = StWeLow;
        timerD = WpLoad;
      end
      StWeLow: begin
        if (timerQ == 4'd0) begin
          stateD = StWeHigh;
          timerD = WhLoad;
        end else begin
          timerD = timerQ - 4'd1;
        end
      end
      StWeHigh: begin
        if (timerQ != 4'd0) begin
          timerD = timerQ - 4'd1;
        end else if (byteCntQ > 3'd1) begin
          // Next byte goes out on the same edge WE_n falls.
          stateD   = StWeLow;
          timerD   = WpLoad;
          byteCntD = byteCntQ - 3'd1;
          dataD    = {dataQ[31:0], 8'h00};
        end else begin
          byteCntD = 3'd0;
`ifdef NFC_CA_LATCH_POSTAMBLE_EN
          stateD   = StPost;
          timerD   = PostLoad;
`else
          stateD   = StDone;
          timerD   = 4'd0;
`endif
        end
      end
`ifdef NFC_CA_LATCH_POSTAMBLE_EN
      StPost: begin
        if (timerQ == 4'd0) begin
          stateD = StDone;
        end else begin
          timerD = timerQ - 4'd1;
        end
      end
`endif
      StDone: begin
        stateD = StIdle;
        timerD = 4'd0;
      end
      default: stateD = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the pins change with the state register.
  always_comb begin
    readyD    = (stateD == StIdle);
    lastStepD = (stateD == StDone);
    ceND      = '1;
    cleD      = 1'b0;
    aleD      = 1'b0;
    weND      = 1'b1;
    dqD       = 8'h00;
    dqoeD     = 1'b0;
    case (stateD)
      StSetup, StWeLow, StWeHigh: begin
        ceND  = ~wayD;
        cleD  = caSelD;
        aleD  = ~caSelD;
        weND  = (stateD != StWeLow);
        dqD   = dataD[39:32];
        dqoeD = 1'b1;
      end
`ifdef NFC_CA_LATCH_POSTAMBLE_EN
      StPost: ceND = ~wayD;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      stateQ        <= StIdle;
      timerQ        <= 4'd0;
      byteCntQ      <= 3'd0;
      wayQ          <= '0;
      caSelQ        <= 1'b0;
      dataQ         <= 40'd0;
      oACG_Ready    <= 1'b1;
      oACG_LastStep <= 1'b0;
      oPO_CE_n      <= '1;
      oPO_CLE       <= 1'b0;
      oPO_ALE       <= 1'b0;
      oPO_WE_n      <= 1'b1;
      oPO_DQ        <= 8'h00;
      oPO_DQOE      <= 1'b0;
    end else begin
      stateQ        <= stateD;
      timerQ        <= timerD;
      byteCntQ      <= byteCntD;
      wayQ          <= wayD;
      caSelQ        <= caSelD;
      dataQ         <= dataD;
      oACG_Ready    <= readyD;
      oACG_LastStep <= lastStepD;
      oPO_CE_n      <= ceND;
      oPO_CLE       <= cleD;
      oPO_ALE       <= aleD;
      oPO_WE_n      <= weND;
      oPO_DQ        <= dqD;
      oPO_DQOE      <= dqoeD;
    end
  end

endmodule

// File: tb/tb_nfc_atom_ca_latch.sv
// Directed bench for nfc_atom_ca_latch: expected bytes are queued at request time and
// compared at each WE_n rising edge; completion timing is checked against cycle numbers.
module tb_nfc_atom_ca_latch;

`ifdef NFC_CA_LATCH_POSTAMBLE_EN
  localparam int Post = 3;
`else
  localparam int Post = 0;
`endif
  localparam int Wp = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  tbCommand;
  logic [3:0]  tbTargetWay;
  logic [15:0] tbNumOfData;
  logic        tbCASelect;
  logic [39:0] tbCAData;
  logic        oACG_Ready, oACG_LastStep, oPO_CLE, oPO_ALE, oPO_WE_n, oPO_DQOE;
  logic [3:0]  oPO_CE_n;
  logic [7:0]  oPO_DQ;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  nfc_atom_ca_latch dut (
    .iSystemClock   (clk),
    .iReset         (rst),
    .iACG_Command   (tbCommand),
    .iACG_TargetWay (tbTargetWay),
    .iACG_NumOfData (tbNumOfData),
    .iACG_CASelect  (tbCASelect),
    .iACG_CAData    (tbCAData),
    .oACG_Ready     (oACG_Ready),
    .oACG_LastStep  (oACG_LastStep),
    .oPO_CE_n       (oPO_CE_n),
    .oPO_CLE        (oPO_CLE),
    .oPO_ALE        (oPO_ALE),
    .oPO_WE_n       (oPO_WE_n),
    .oPO_DQ         (oPO_DQ),
    .oPO_DQOE       (oPO_DQOE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_ready"}, oACG_Ready, 1'b1);
    check({tag, "_last"}, oACG_LastStep, 1'b0);
    check({tag, "_ce"}, oPO_CE_n, 4'hF);
    check({tag, "_cle"}, oPO_CLE, 1'b0);
    check({tag, "_ale"}, oPO_ALE, 1'b0);
    check({tag, "_we"}, oPO_WE_n, 1'b1);
    check({tag, "_dq"}, oPO_DQ, 8'h00);
    check({tag, "_dqoe"}, oPO_DQOE, 1'b0);
  endtask

  task automatic pushBytes(input logic [39:0] data, input int nbytes);
    logic [39:0] sh;
    sh = data;
    for (int i = 0; i < nbytes; i++) begin
      expQ.push_back(sh[39:32]);
      sh = {sh[31:0], 8'h00};
    end
  endtask

  // Called at a negedge in IDLE; that cycle is cycle 0 of the transfer.
  task automatic xfer(input logic [3:0] way, input logic cas, input logic [39:0] data,
                      input logic [15:0] num, input int nbytes, input int expLast,
                      input bit busyPulse, input bit holdOnce);
    int c, lowCount, pulses;
    bit prevWe, again, seenLast, done;
    logic [3:0] ceExp;
    logic [7:0] firstByte, popped;
    ceExp = ~way;
    firstByte = data[39:32];
    tbTargetWay = way;
    tbCASelect = cas;
    tbCAData = data;
    tbNumOfData = num;
    tbCommand = 8'h40;
    expQ.delete();
    pushBytes(data, nbytes);
    c = 0; lowCount = 0; pulses = 0;
    prevWe = 1'b1; again = holdOnce; seenLast = 1'b0; done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        check("setup_ce", oPO_CE_n, ceExp);
        check("setup_cle", oPO_CLE, cas);
        check("setup_ale", oPO_ALE, !cas);
        check("setup_we", oPO_WE_n, 1'b1);
        check("setup_dqoe", oPO_DQOE, 1'b1);
        check("setup_dq", oPO_DQ, firstByte);
        check("setup_ready", oACG_Ready, 1'b0);
      end
      if (c == 2) check("first_we_low", oPO_WE_n, 1'b0);
      if (!oPO_WE_n) lowCount++;
      if (!prevWe && oPO_WE_n) begin
        pulses++;
        if (expQ.size() > 0) begin
          popped = expQ.pop_front();
          check("dq_at_we_rise", oPO_DQ, popped);
          check("ce_at_we_rise", oPO_CE_n, ceExp);
        end
      end
      prevWe = oPO_WE_n;
      if (c >= expLast - Post && c < expLast) begin
        check("post_ce", oPO_CE_n, ceExp);
        check("post_we", oPO_WE_n, 1'b1);
        check("post_dqoe", oPO_DQOE, 1'b0);
      end
      if (seenLast) begin
        check("ready_after_last", oACG_Ready, 1'b1);
        check("last_one_cycle", oACG_LastStep, 1'b0);
        if (again) begin
          again = 1'b0;
          pushBytes(data, nbytes);
          c = 0; lowCount = 0; pulses = 0;
          prevWe = 1'b1; seenLast = 1'b0;
        end else begin
          done = 1'b1;
        end
      end else if (oACG_LastStep) begin
        check("last_cycle", c, expLast);
        check("pulse_count", pulses, nbytes);
        check("we_low_cycles", lowCount, nbytes * Wp);
        check("done_ready", oACG_Ready, 1'b0);
        check("done_ce", oPO_CE_n, 4'hF);
        check("done_dqoe", oPO_DQOE, 1'b0);
        seenLast = 1'b1;
      end
      if (c == 1 && !again) tbCommand = 8'h00;
      if (busyPulse && c == 3) begin
        tbCommand = 8'h40;
        tbCAData = 40'hDE_AD_BE_EF_77;
        tbNumOfData = 16'd5;
        tbCASelect = !cas;
      end
      if (busyPulse && c == 4) tbCommand = 8'h00;
    end
    if (!done) check("xfer_timeout", done, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    tbCommand = 8'h00;
    tbTargetWay = 4'b0000;
    tbNumOfData = 16'd0;
    tbCASelect = 1'b0;
    tbCAData = 40'd0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Other command bits must not start the engine.
    tbCommand = 8'hBF;
    repeat (4) @(negedge clk);
    check("other_bits_ready", oACG_Ready, 1'b1);
    check("other_bits_we", oPO_WE_n, 1'b1);
    check("other_bits_ce", oPO_CE_n, 4'hF);
    tbCommand = 8'h00;

    xfer(4'b0001, 1'b1, 40'hFF_00_00_00_00, 16'd1, 1, 6 + Post, 1'b0, 1'b0);
    xfer(4'b0010, 1'b0, 40'h11_22_33_44_55, 16'd5, 5, 22 + Post, 1'b0, 1'b0);
    xfer(4'b1000, 1'b0, 40'hAB_CD_EF_01_23, 16'd0, 1, 6 + Post, 1'b0, 1'b0);
    xfer(4'b0100, 1'b0, 40'h11_22_33_44_55, 16'd9, 5, 22 + Post, 1'b0, 1'b0);
    xfer(4'b0001, 1'b1, 40'hA1_B2_00_00_00, 16'd2, 2, 10 + Post, 1'b1, 1'b0);
    xfer(4'b0011, 1'b1, 40'h70_00_00_00_00, 16'd1, 1, 6 + Post, 1'b0, 1'b1);

    // Asynchronous reset while WE_n is low.
    tbTargetWay = 4'b0001;
    tbCASelect = 1'b1;
    tbCAData = 40'h5A_00_00_00_00;
    tbNumOfData = 16'd1;
    tbCommand = 8'h40;
    @(negedge clk);
    tbCommand = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_we_low", oPO_WE_n, 1'b0);
    rst = 1'b1;
    #1;
    checkIdleOutputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", oACG_Ready, 1'b1);
    check("post_reset_we", oPO_WE_n, 1'b1);

    xfer(4'b0010, 1'b0, 40'h01_02_03_00_00, 16'd3, 3, 14 + Post, 1'b0, 1'b0);
    xfer(4'b1111, 1'b1, 40'h90_00_00_00_00, 16'd1, 1, 6 + Post, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkIdleOutputs("final_idle");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
